// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with LRU replacement.
// A miss latches a victim way, optionally writes it back, fetches the block and installs it.
module dcache_assoc #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16,
  localparam int OFF_W   = $clog2(WORDS),
  localparam int IDX_W   = $clog2(SETS),
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W,
  localparam int BLK_W   = DATA_W * WORDS,
  localparam int MADDR_W = ADDR_W - OFF_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [MADDR_W-1:0] mem_address,
  output logic [BLK_W-1:0]   mem_writedata,
  input  logic [BLK_W-1:0]   mem_readdata,
  input  logic               mem_busywait,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             first_q, first_d;
  logic             missed_q, missed_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             valid_q [WAYS][SETS];
  logic             valid_d [WAYS][SETS];
  logic             dirty_q [WAYS][SETS];
  logic             dirty_d [WAYS][SETS];
  logic [WAY_W-1:0] rank_q  [WAYS][SETS];
  logic [WAY_W-1:0] rank_d  [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [TAG_W-1:0] tag_d   [WAYS][SETS];
  logic [BLK_W-1:0] data_q  [WAYS][SETS];
  logic [BLK_W-1:0] data_d  [WAYS][SETS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  int               off_lsb;
  logic             req, hit, touch_en;
  logic [WAY_W-1:0] hit_way, pick_way, touch_way;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req_tag = address[ADDR_W-1 -: TAG_W];
  assign req_idx = address[OFF_W +: IDX_W];
  assign req_off = address[OFF_W-1:0];
  assign off_lsb = int'(req_off) * DATA_W;
  assign req     = read | write;

  // Lookup and victim choice: first invalid way, otherwise the way holding the oldest rank.
  always_comb begin
    logic found;
    hit      = 1'b0;
    hit_way  = '0;
    pick_way = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (rank_q[w][req_idx] == WAY_W'(WAYS - 1)) pick_way = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[w][req_idx]) begin
        pick_way = WAY_W'(w);
        found    = 1'b1;
      end
    end
  end

  assign readdata   = data_q[hit_way][req_idx][off_lsb +: DATA_W];
  assign busywait   = req & ~((state_q == IDLE) & hit) & ~reset;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    first_d       = 1'b0;
    missed_d      = missed_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    rank_d        = rank_q;
    tag_d         = tag_q;
    data_d        = data_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {req_tag, req_idx};
    mem_writedata = data_q[victim_q][req_idx];
    touch_en      = 1'b0;
    touch_way     = hit_way;

    case (state_q)
      IDLE: begin
        if (req && hit) begin
          touch_en = 1'b1;
          if (write) begin
            data_d[hit_way][req_idx][off_lsb +: DATA_W] = writedata;
            dirty_d[hit_way][req_idx] = 1'b1;
          end
          if (missed_q) miss_cnt_d = sat_inc(miss_cnt_q);
          else          hit_cnt_d  = sat_inc(hit_cnt_q);
          missed_d = 1'b0;
        end else if (req) begin
          victim_d = pick_way;
          missed_d = 1'b1;
          first_d  = 1'b1;
          state_d  = (valid_q[pick_way][req_idx] && dirty_q[pick_way][req_idx]) ? WRITEBACK : FETCH;
        end
      end
      // The memory handshake is only trusted from the second cycle of a transfer on.
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {tag_q[victim_q][req_idx], req_idx};
        if (!first_q && !mem_busywait) begin
          state_d = FETCH;
          first_d = 1'b1;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        if (!first_q && !mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        data_d[victim_q][req_idx]  = mem_readdata;
        tag_d[victim_q][req_idx]   = req_tag;
        valid_d[victim_q][req_idx] = 1'b1;
        dirty_d[victim_q][req_idx] = 1'b0;
        touch_en  = 1'b1;
        touch_way = victim_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Touched way becomes rank 0; ways that were younger than it age by one.
    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          rank_d[w][req_idx] = '0;
        else if (rank_q[w][req_idx] < rank_q[touch_way][req_idx])
          rank_d[w][req_idx] = rank_q[w][req_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      victim_q   <= '0;
      first_q    <= 1'b0;
      missed_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          rank_q[w][s]  <= WAY_W'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      first_q    <= first_d;
      missed_q   <= missed_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rank_q     <= rank_d;
    end
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
